fp_mant_norm_round_pipe: RTL and testbench

- Parametrised, pipelined successor to the multiplier mantissa bit-select stage.
- Takes the full (MANT_W+1)x(MANT_W+1) significand product and a signed normalisation shift, extracts the MANT_W-bit fraction, and derives guard/sticky bits.
- Optionally rounds the result and reports exponent increment, inexact and range-error flags.
- Sits between the significand multiplier and the exponent adjust / pack stage, with a valid/ready handshake on both sides.

---
 rtl/fp_mant_norm_round_pipe.sv | 129 ++++++++++++
 tb/tb_fp_mant_norm_round_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mant_norm_round_pipe.sv
// Two-stage elastic mantissa select/round stage between significand multiplier and exponent adjust.
// Build option: define MANT_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_mant_norm_round_pipe #(
  parameter int MANT_W  = 23,
  parameter int SHIFT_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*MANT_W+1:0]   in_product,
  input  logic [SHIFT_W-1:0]    in_shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANT_W-1:0]     out_mant,
  output logic                  out_exp_inc,
  output logic                  out_inexact,
  output logic                  out_range_err
);

  localparam int PW = 2 * MANT_W + 2;
  localparam int XW = PW + 1;
  localparam logic signed [SHIFT_W:0] SH_MIN = (SHIFT_W + 1)'(-MANT_W);
  localparam logic signed [SHIFT_W:0] SH_MAX = (SHIFT_W + 1)'(1);
  localparam logic signed [SHIFT_W:0] L_OFF  = (SHIFT_W + 1)'(MANT_W);

  // Stage registers
  logic              s1_valid;
  logic [MANT_W-1:0] s1_frac;
  logic              s1_guard;
  logic              s1_sticky;
  logic              s1_rerr;

  logic              s2_valid;
  logic [MANT_W-1:0] s2_mant;
  logic              s2_exp_inc;
  logic              s2_inexact;
  logic              s2_rerr;

  // Handshake: a stage may load when it is empty or its content leaves this cycle
  logic s2_free;
  logic s1_free;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_free  = !s1_valid || s2_free;
  assign in_ready = s1_free;

  // Stage 1 select logic
  logic signed [SHIFT_W:0] shift_ext;
  logic [SHIFT_W:0]        lsb_idx;
  logic [XW-1:0]           ext_product;
  logic [XW-1:0]           below_mask;
  logic                    range_ok;
  logic [MANT_W-1:0]       sel_frac;
  logic                    sel_guard;
  logic                    sel_sticky;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    shift_ext   = {in_shift[SHIFT_W-1], in_shift};
    range_ok    = (shift_ext >= SH_MIN) && (shift_ext <= SH_MAX);
    lsb_idx     = shift_ext + L_OFF;
    // Appending a zero below the product turns bit L of the shifted vector into the guard bit
    ext_product = {in_product, 1'b0};
    below_mask  = ~({XW{1'b1}} << lsb_idx);
    sel_frac    = range_ok ? MANT_W'(in_product >> lsb_idx) : '0;
    sel_guard   = range_ok && 1'(ext_product >> lsb_idx);
    sel_sticky  = range_ok && (|(ext_product & below_mask));
  end

  // Stage 2 rounding logic
  logic              round_up;
  logic [MANT_W:0]   rounded;

  always_comb begin
`ifdef MANT_RNE_EN
    round_up = s1_guard && (s1_sticky || s1_frac[0]) && !s1_rerr;
`else
    round_up = 1'b0;
`endif
    // A carry out of an all-ones fraction lands in the top bit and wraps the fraction to zero
    rounded  = {1'b0, s1_frac} + (MANT_W + 1)'(round_up);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data registers are reset as well, because the outputs must read zero after reset.
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_frac   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_rerr   <= 1'b0;
    end else if (s1_free) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_frac   <= sel_frac;
        s1_guard  <= sel_guard;
        s1_sticky <= sel_sticky;
        s1_rerr   <= !range_ok;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_mant    <= '0;
      s2_exp_inc <= 1'b0;
      s2_inexact <= 1'b0;
      s2_rerr    <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mant    <= rounded[MANT_W-1:0];
        s2_exp_inc <= rounded[MANT_W];
        s2_inexact <= s1_guard || s1_sticky;
        s2_rerr    <= s1_rerr;
      end
    end
  end

  assign out_valid     = s2_valid;
  assign out_mant      = s2_mant;
  assign out_exp_inc   = s2_exp_inc;
  assign out_inexact   = s2_inexact;
  assign out_range_err = s2_rerr;

endmodule

// File: tb/tb_fp_mant_norm_round_pipe.sv
// Self-checking bench for fp_mant_norm_round_pipe: directed cases, backpressure, mid-flight reset
// and a randomized run compared against a bit-level model of the selection and rounding rules.
module tb_fp_mant_norm_round_pipe;

  localparam int MW = 23;
  localparam int SW = 10;
  localparam int PW = 2 * MW + 2;

  typedef struct packed {
    logic [MW-1:0] mant;
    logic          inc;
    logic          inexact;
    logic          rerr;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_product = '0;
  logic [SW-1:0] in_shift = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] out_mant;
  logic          out_exp_inc;
  logic          out_inexact;
  logic          out_range_err;

  int total = 0;
  int bad   = 0;
  res_t exp_q[$];

  fp_mant_norm_round_pipe #(.MANT_W(MW), .SHIFT_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_shift     (in_shift),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mant     (out_mant),
    .out_exp_inc  (out_exp_inc),
    .out_inexact  (out_inexact),
    .out_range_err(out_range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic res_t mk(input logic [MW-1:0] m, input logic inc, input logic inx,
                              input logic rerr);
    res_t r;
    r.mant = m; r.inc = inc; r.inexact = inx; r.rerr = rerr;
    return r;
  endfunction

  // Reference: walk the product bit by bit from the fraction LSB index L = MW + shift
  function automatic res_t model(input logic [PW-1:0] p, input logic [SW-1:0] sh);
    res_t          r;
    int            s;
    int            l;
    logic [MW-1:0] frac;
    logic          g;
    logic          st;
    logic [MW:0]   sum;
    r = '0;
    s = int'($signed(sh));
    if (s < -MW || s > 1) begin
      r.rerr = 1'b1;
      return r;
    end
    l = MW + s;
    frac = '0; g = 1'b0; st = 1'b0;
    for (int i = 0; i < MW; i++) frac[i] = p[l + i];
    if (l > 0) g = p[l - 1];
    for (int i = 0; i < l - 1; i++) st = st | p[i];
    r.inexact = g | st;
`ifdef MANT_RNE_EN
    sum = {1'b0, frac};
    if (g && (st || frac[0])) sum = sum + (MW + 1)'(1);
    r.mant = sum[MW-1:0];
    r.inc  = sum[MW];
`else
    sum = '0;
    r.mant = frac;
    r.inc  = sum[MW];
`endif
    return r;
  endfunction

  function automatic res_t cur_out();
    return mk(out_mant, out_exp_inc, out_inexact, out_range_err);
  endfunction

  // Compare process: scoreboard checks and stall stability, sampled on the falling edge
  initial begin
    res_t held;
    res_t want;
    logic stalled;
    held = '0;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid_held", out_valid, 1'b1);
          check("stall_data_held", cur_out(), held);
        end
        if (out_valid) begin
          check("out_has_beat", exp_q.size() != 0, 1'b1);
          if (out_ready && exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("model", cur_out(), want);
          end
        end
        stalled = out_valid && !out_ready;
        held = cur_out();
        if (in_valid && in_ready) exp_q.push_back(model(in_product, in_shift));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [PW-1:0] p, input logic [SW-1:0] sh);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_product = p;
    in_shift = sh;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic run_one(input logic [PW-1:0] p, input logic [SW-1:0] sh, output res_t r,
                         output int lat);
    out_ready = 1'b1;
    send(p, sh);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    r = cur_out();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_product();
    logic [63:0]   w;
    logic [PW-1:0] p;
    w = {$urandom(), $urandom()};
    p = w[PW-1:0];
    if ($urandom_range(0, 2) == 0) p = p & ~((PW'(1) << $urandom_range(0, PW - 1)) - PW'(1));
    if ($urandom_range(0, 15) == 0) p = '1;
    return p;
  endfunction

  function automatic logic [SW-1:0] rand_shift();
    case ($urandom_range(0, 15))
      0:       return SW'($urandom());
      1:       return SW'(2);
      2:       return SW'(-24);
      default: return SW'(int'($urandom_range(0, 24)) - 23);
    endcase
  endfunction

  initial begin
    res_t          r;
    int            lat;
    int            idx;
    logic          acc;
    logic [PW-1:0] bp_p [4];

    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outputs", cur_out(), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases with hand-derived results
    run_one(48'h7FFF_FF00_0000, SW'(1), r, lat);
    check("basic_result", r, mk(23'h7FFFFF, 1'b0, 1'b0, 1'b0));
    check("basic_latency", lat, 2);

    run_one(48'h0000_00C0_0000, SW'(0), r, lat);
`ifdef MANT_RNE_EN
    check("tie_odd_result", r, mk(23'h000002, 1'b0, 1'b1, 1'b0));
`else
    check("tie_odd_result", r, mk(23'h000001, 1'b0, 1'b1, 1'b0));
`endif

    run_one(48'h3FFF_FFC0_0000, SW'(0), r, lat);
`ifdef MANT_RNE_EN
    check("carry_result", r, mk(23'h000000, 1'b1, 1'b1, 1'b0));
`else
    check("carry_result", r, mk(23'h7FFFFF, 1'b0, 1'b1, 1'b0));
`endif

    run_one(48'h0000_0000_0001, SW'(-23), r, lat);
    check("shift_min_result", r, mk(23'h000001, 1'b0, 1'b0, 1'b0));
    run_one(48'hFFFF_FFFF_FFFF, SW'(2), r, lat);
    check("shift_hi_err", r, mk(23'h000000, 1'b0, 1'b0, 1'b1));
    run_one(48'hFFFF_FFFF_FFFF, SW'(-24), r, lat);
    check("shift_lo_err", r, mk(23'h000000, 1'b0, 1'b0, 1'b1));

    // Backpressure: four beats, output stalled for the first three cycles
    foreach (bp_p[i]) bp_p[i] = rand_product();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready  = (c >= 3);
      in_valid   = (idx < 4);
      in_product = bp_p[idx % 4];
      in_shift   = SW'(idx - 5);
      @(negedge clk);
      if (c == 2) check("bp_in_ready_low", in_ready, 1'b0);
      if (c == 3 || c == 4) check("bp_full_rate", in_ready, 1'b1);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 4);
    check("bp_all_emerged", exp_q.size(), 0);

    // Reset with two beats held in the pipeline
    out_ready = 1'b0;
    send(48'hFFFF_FFFF_FFFF, SW'(0));
    send(48'hFFFF_FFFF_FFFF, SW'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_outputs", cur_out(), '0);
    check("midrst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_beat", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure, holding each offered beat until taken
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || acc) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        in_product = rand_product();
        in_shift   = rand_shift();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("random_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
